mem_ctrl_bridge: RTL and testbench

MEM_CTRL_BRIDGE -- requirements
Module: mem_ctrl_bridge

---
 rtl/mem_ctrl_bridge.sv | 172 +++++++++++++++++
 tb/tb_mem_ctrl_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_bridge.sv
// Processor-to-memory bridge: local synchronous RAM plus N_PERIPH peripheral slots.
// Define MEM_CTRL_BRIDGE_TIMEOUT_EN to bound the peripheral wait by TIMEOUT cycles.
module mem_ctrl_bridge #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int LOCAL_AW = 12,
  parameter int N_PERIPH = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       local_mem_we,
  output logic [LOCAL_AW-1:0]        local_mem_addr,
  output logic [DATA_W-1:0]          local_mem_in,
  input  logic [DATA_W-1:0]          local_mem_out,
  output logic [N_PERIPH-1:0]        p_sel,
  output logic                       p_we,
  output logic [3:0]                 p_addr,
  output logic [DATA_W-1:0]          p_wdata,
  input  logic [N_PERIPH*DATA_W-1:0] p_rdata,
  input  logic [N_PERIPH-1:0]        p_ready
);

  typedef enum logic [1:0] {
    IDLE, LOCAL, PERIPH, RESP
  } state_t;

  localparam int SW = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  localparam logic [ADDR_W-1:0] LOCAL_SZ = ADDR_W'(1) << LOCAL_AW;
  localparam logic [ADDR_W-1:0] P_SPAN = ADDR_W'(16 * N_PERIPH);

  state_t state, state_nxt;

  logic              req_we;
  logic [3:0]        req_reg;
  logic [DATA_W-1:0] req_wdata;
  logic [SW-1:0]     req_slot;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_err;

  logic              accept;
  logic              local_hit;
  logic              periph_hit;
  logic [ADDR_W-1:0] off;
  logic [SW-1:0]     slot;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              expired;

  // rst gates accept so nothing is strobed while reset is held
  assign accept     = (state == IDLE) && cpu_req && rst;
  assign local_hit  = (cpu_addr >> LOCAL_AW) == '0;
  assign off        = cpu_addr - LOCAL_SZ;
  assign periph_hit = !local_hit && (off < P_SPAN);
  assign slot       = SW'(off >> 4);
  assign sel_ready  = p_ready[req_slot];
  assign sel_rdata  = p_rdata[int'(req_slot)*DATA_W +: DATA_W];

`ifdef MEM_CTRL_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  assign expired = (state == PERIPH) && (tmo_cnt == CW'(TIMEOUT - 1));

  // Wait counter: restarts with each access, advances while the slot stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == PERIPH && !sel_ready && !expired) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Latch the accepted request and capture the response payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we    <= 1'b0;
      req_reg   <= '0;
      req_wdata <= '0;
      req_slot  <= '0;
      cap_rdata <= '0;
      cap_err   <= 1'b0;
    end else if (accept) begin
      req_we    <= cpu_we;
      req_reg   <= cpu_addr[3:0];
      req_wdata <= cpu_wdata;
      req_slot  <= slot;
      cap_rdata <= '0;
      cap_err   <= !local_hit && !periph_hit;
    end else if (state == PERIPH && sel_ready) begin
      cap_rdata <= req_we ? '0 : sel_rdata;
      cap_err   <= 1'b0;
    end else if (expired) begin
      cap_rdata <= '0;
      cap_err   <= 1'b1;
    end
  end

  // Next-state: route by address region, finish on slot ready or expiry
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (local_hit)       state_nxt = LOCAL;
          else if (periph_hit) state_nxt = PERIPH;
          else                 state_nxt = RESP;
        end
      end
      LOCAL:  state_nxt = IDLE;
      PERIPH: if (sel_ready || expired) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
    endcase
  end

  // Outputs: local strobe in the accept cycle, slot bus in PERIPH, reply in LOCAL/RESP
  always_comb begin
    cpu_ready      = 1'b0;
    cpu_err        = 1'b0;
    cpu_rdata      = '0;
    local_mem_we   = 1'b0;
    local_mem_addr = '0;
    local_mem_in   = '0;
    p_sel          = '0;
    p_we           = 1'b0;
    p_addr         = '0;
    p_wdata        = '0;
    unique case (state)
      IDLE: begin
        if (accept && local_hit) begin
          local_mem_we   = cpu_we;
          local_mem_addr = cpu_addr[LOCAL_AW-1:0];
          local_mem_in   = cpu_we ? cpu_wdata : '0;
        end
      end
      LOCAL: begin
        cpu_ready = 1'b1;
        cpu_rdata = req_we ? '0 : local_mem_out;
      end
      PERIPH: begin
        p_sel   = N_PERIPH'(1) << req_slot;
        p_we    = req_we;
        p_addr  = req_reg;
        p_wdata = req_wdata;
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_err   = cap_err;
        cpu_rdata = cap_rdata;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_bridge.sv
// Bench for mem_ctrl_bridge: transaction-level timeline model, per-cycle compare,
// plus literal pins. Honours MEM_CTRL_BRIDGE_TIMEOUT_EN like the design.
module tb_mem_ctrl_bridge;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [13:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic         cpu_err;
  logic [31:0]  cpu_rdata;
  logic         local_mem_we;
  logic [11:0]  local_mem_addr;
  logic [31:0]  local_mem_in;
  logic [31:0]  local_mem_out;
  logic [3:0]   p_sel;
  logic         p_we;
  logic [3:0]   p_addr;
  logic [31:0]  p_wdata;
  logic [127:0] p_rdata;
  logic [3:0]   p_ready;

  mem_ctrl_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .local_mem_we(local_mem_we),
    .local_mem_addr(local_mem_addr),
    .local_mem_in(local_mem_in),
    .local_mem_out(local_mem_out),
    .p_sel(p_sel), .p_we(p_we), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdata(p_rdata),
    .p_ready(p_ready)
  );

  typedef struct packed {
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    logic        lwe;
    logic [11:0] laddr;
    logic [31:0] lin;
    logic [3:0]  psel;
    logic        pwe;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
  } obs_t;

  typedef struct {
    int          c;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n_resp = 0;
  obs_t        expq [int];
  resp_t       resp_log [$];
  int          acc_log [$];
  logic [31:0] model_mem [int];
  logic [31:0] pval [4];
  logic [31:0] ram [4096];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side synchronous RAM behind the local port
  always @(posedge clk) begin
    if (local_mem_we) ram[local_mem_addr] <= local_mem_in;
    local_mem_out <= ram[local_mem_addr];
  end

  assign p_rdata = {pval[3], pval[2], pval[1], pval[0]};

  // Per-cycle compare; cycles without an entry must be fully quiet
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    e = expq.exists(cyc) ? expq[cyc] : '0;
    a = {cpu_ready, cpu_err, cpu_rdata, local_mem_we, local_mem_addr,
         local_mem_in, p_sel, p_we, p_addr, p_wdata};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outputs cycle %0d: got %h want %h", cyc, a, e);
    end
    if (cpu_ready === 1'b1) resp_log.push_back('{cyc, cpu_rdata, cpu_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busy(input logic we);
    cpu_req   = 1'b1;
    cpu_we    = ~we;
    cpu_addr  = 14'h3FFF;
    cpu_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] mm(input logic [11:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
  endfunction

  // One access from the model's point of view. dly: cycle of p_ready (<0 never).
  // abort>0: assert reset after that many wait cycles.
  task automatic access(input logic we, input logic [13:0] a, input logic [31:0] wd,
                        input int dly, input logic [3:0] noise, input int abort);
    obs_t        e;
    int          k;
    int          n;
    logic [3:0]  oh;
    logic [31:0] rd;
    logic        tmo;
    acc_log.push_back(cyc);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    e = '0;
    if (a < 14'h1000) begin
      e.lwe = we;
      e.laddr = a[11:0];
      e.lin = we ? wd : 32'h0;
      expq[cyc] = e;
      rd = we ? 32'h0 : mm(a[11:0]);
      if (we) model_mem[int'(a[11:0])] = wd;
      step();
      busy(we);
      e = '0;
      e.ready = 1'b1;
      e.rdata = rd;
      expq[cyc] = e;
      n_resp++;
    end else if (a < 14'h1040) begin
      expq[cyc] = e;
      k = (int'(a) - 4096) / 16;
      oh = 4'(1 << k);
      tmo = 1'b0;
      n = dly;
`ifdef MEM_CTRL_BRIDGE_TIMEOUT_EN
      if (dly < 0 || dly > 15) begin
        tmo = 1'b1;
        n = 15;
      end
`endif
      if (abort > 0) n = abort;
      for (int i = 1; i <= n; i++) begin
        step();
        busy(we);
        p_ready = (noise & ~oh) | ((i == dly) ? oh : 4'b0);
        e = '0;
        e.psel = oh;
        e.pwe = we;
        e.paddr = a[3:0];
        e.pwdata = wd;
        expq[cyc] = e;
      end
      if (abort > 0) begin
        #2 rst = 1'b0;
        #1;
        total++;
        if (p_sel !== 4'b0 || cpu_ready !== 1'b0) begin
          bad++;
          $display("FAIL async_reset: got p_sel=%b ready=%b want 0000/0", p_sel, cpu_ready);
        end
        expq.delete();
        p_ready = 4'b0;
        void'(acc_log.pop_back());
        step();
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h0005;
        cpu_wdata = 32'hFFFF_FFFF;
        step();
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        return;
      end
      step();
      busy(we);
      p_ready = 4'b0;
      e = '0;
      e.ready = 1'b1;
      e.err = tmo;
      e.rdata = (tmo || we) ? 32'h0 : pval[k];
      expq[cyc] = e;
      n_resp++;
    end else begin
      expq[cyc] = e;
      step();
      busy(we);
      e = '0;
      e.ready = 1'b1;
      e.err = 1'b1;
      expq[cyc] = e;
      n_resp++;
    end
    step();
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    pval[0] = 32'h1111_0000;
    pval[1] = 32'h0000_0A5A;
    pval[2] = 32'h2222_0002;
    pval[3] = 32'hCAFE_0003;
    rst = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    p_ready = 4'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    access(1'b1, 14'h0005, 32'hDEAD_BEEF, 0, 4'b0, 0);
    access(1'b0, 14'h0005, 32'h0, 0, 4'b0, 0);
    access(1'b0, 14'h1013, 32'h0, 3, 4'b0, 0);
    access(1'b0, 14'h1040, 32'h0, 0, 4'b0, 0);
    access(1'b1, 14'h1035, 32'h1234_5678, 1, 4'b0001, 0);
    access(1'b0, 14'h1032, 32'h0, 4, 4'b0111, 0);
    access(1'b1, 14'h0FFF, 32'h0BAD_F00D, 0, 4'b0, 0);
    access(1'b0, 14'h0FFF, 32'h0, 0, 4'b0, 0);
    access(1'b0, 14'h1000, 32'h0, 1, 4'b0, 0);
    access(1'b0, 14'h103F, 32'h0, 2, 4'b1000, 0);
    access(1'b0, 14'h3FFF, 32'h0, 0, 4'b0, 0);
    step();
    access(1'b0, 14'h1024, 32'h0, 15, 4'b0, 0);
`ifdef MEM_CTRL_BRIDGE_TIMEOUT_EN
    access(1'b0, 14'h1020, 32'h0, -1, 4'b0, 0);
`else
    access(1'b0, 14'h1020, 32'h0, -1, 4'b0, 110);
`endif
    access(1'b0, 14'h1011, 32'h0, -1, 4'b0, 3);
    access(1'b0, 14'h0000, 32'h0, 0, 4'b0, 0);
    access(1'b0, 14'h0005, 32'h0, 0, 4'b0, 0);
    repeat (3) step();

    pin("rd5_data", resp_log[1].rdata, 32'hDEAD_BEEF);
    pin("rd5_latency", 32'(resp_log[1].c - acc_log[1]), 32'd1);
    pin("rd1013_data", resp_log[2].rdata, 32'h0000_0A5A);
    pin("rd1013_latency", 32'(resp_log[2].c - acc_log[2]), 32'd4);
    pin("rd1040_err", {31'b0, resp_log[3].err}, 32'd1);
    pin("rd1040_data", resp_log[3].rdata, 32'h0);
    pin("rd1040_latency", 32'(resp_log[3].c - acc_log[3]), 32'd1);
    pin("resp_count", 32'(resp_log.size()), 32'(n_resp));
    pin("rd5_after_reset", resp_log[resp_log.size()-1].rdata, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
